// File: rtl/rc_to_bank_pipe_if.sv
// Request/result bundle for the row/column -> bank/entry mapper.
//   in_valid/in_ready   : request handshake (producer -> mapper)
//   in_row/in_column    : tile coordinate, RW bits each
//   in_bitwidth         : 0/1/2 legal, 3 reserved
//   out_valid/out_ready : result handshake (mapper -> bank write ports)
//   out_bank/out_entry  : physical location, BW/RW bits
//   out_err             : request was illegal, location forced to 0
// slave = the mapper, master = the coordinate producer / result consumer.
interface rc_to_bank_pipe_if #(
  parameter int RW = 8,
  parameter int BW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic [RW-1:0] in_column;
  logic [1:0]    in_bitwidth;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_bank;
  logic [RW-1:0] out_entry;
  logic          out_err;

  modport slave (
    input  in_valid, in_row, in_column, in_bitwidth, out_ready,
    output in_ready, out_valid, out_bank, out_entry, out_err
  );

  modport master (
    output in_valid, in_row, in_column, in_bitwidth, out_ready,
    input  in_ready, out_valid, out_bank, out_entry, out_err
  );
endinterface

// File: rtl/rc_to_bank_pipe.sv
// Inverse tile-buffer address mapper: (row, column, bitwidth) -> (bank, entry).
// Undoes the forward mapping (sub-buffer packing by bitwidth, then a skew of
// 3 banks per entry). Two-stage valid/ready pipeline, one request per cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rc_to_bank_pipe_if.slave (request in, result out)
module rc_to_bank_pipe #(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  rc_to_bank_pipe_if.slave   bus
);
  localparam int RW     = $clog2(TILE_SIZE);
  localparam int BW     = $clog2(BANK_COUNT);
  localparam int SW     = RW + 3;  // holds col_raw + entry*3 without overflow
  localparam int STAGES = 2;

  typedef struct packed {
    logic [RW-1:0] entry;
    logic [BW-1:0] col_raw;
    logic          err;
  } s1_t;

  typedef struct packed {
    logic [BW-1:0] bank;
    logic [RW-1:0] entry;
    logic          err;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic            s2_load, accept;
  logic [1:0]      bw, lsb;
  logic [BW-1:0]   col_mask;
  logic [SW-1:0]   bank_sum;

  // Ready depends only on pipeline state and out_ready, never on in_valid.
  assign s2_load     = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = !vld_pipe[1] || s2_load;
  assign accept      = bus.in_valid && bus.in_ready;

  // Stage 1: split the row into entry and sub-buffer index (lsb); the lsb
  // lands in the top bw bits of the raw column.
  always_comb begin
    bw           = bus.in_bitwidth;
    lsb          = bus.in_row[1:0] & ((2'd1 << bw) - 2'd1);
    col_mask     = {BW{1'b1}} >> bw;
    s1_d.entry   = bus.in_row >> bw;
    s1_d.col_raw = (BW'(lsb) << (BW - int'(bw))) | (bus.in_column[BW-1:0] & col_mask);
    // Full column compared, so out-of-range high bits flag rather than alias.
    s1_d.err     = (bw == 2'd3) || (int'(bus.in_column) >= (BANK_COUNT >> bw));
  end

  // Stage 2: re-apply the entry skew; power-of-two modulo of the wide sum.
  always_comb begin
    bank_sum   = SW'(s1_q.col_raw) + SW'(s1_q.entry) * SW'(3);
    s2_d.bank  = s1_q.err ? '0 : BW'(bank_sum % SW'(BANK_COUNT));
    s2_d.entry = s1_q.err ? '0 : s1_q.entry;
    s2_d.err   = s1_q.err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (bus.in_ready) vld_pipe[1] <= bus.in_valid;
      if (accept)       s1_q        <= s1_d;
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.out_bank  = s2_q.bank;
  assign bus.out_entry = s2_q.entry;
  assign bus.out_err   = s2_q.err;
endmodule

// File: tb/tb_rc_to_bank_pipe.sv
// Directed + streaming bench for rc_to_bank_pipe at default parameters
// (32 banks, 256-entry tiles). Streamed results are checked by pushing
// (bank, entry, bw) through an independent forward mapper.
module tb_rc_to_bank_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc_to_bank_pipe_if #(.RW(8), .BW(5)) bus ();

  rc_to_bank_pipe #(.BANK_COUNT(32), .TILE_SIZE(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { int row; int col; int bw; } req_t;
  req_t req_q[$];
  req_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cnt [3][256][32];

  // Forward mapping: bank/entry/bw -> row/column.
  function automatic void fwd(input int bank, input int entry, input int bw,
                              output int row, output int col);
    int skew, craw;
    skew = (entry * 3) % 32;
    craw = (bank - skew + 32) % 32;
    row  = (entry << bw) | (craw >> (5 - bw));
    col  = craw & ((32 >> bw) - 1);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_row = 0; bus.in_column = 0; bus.in_bitwidth = 0;
    bus.out_ready = 1;
    rst_n = 0;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_bank !== 5'd0 || bus.out_entry !== 8'd0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b bank=%0d entry=%0d err=%b, required 0/0/0/0",
               bus.out_valid, bus.out_bank, bus.out_entry, bus.out_err);
    end
    rst_n = 1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
  endtask

  // One isolated request; checks latency and the result.
  task automatic send_one(input string name, input int row, input int col, input int bw,
                          input int e_bank, input int e_entry, input bit e_err);
    bus.out_ready = 1;
    bus.in_valid = 1; bus.in_row = 8'(row); bus.in_column = 8'(col); bus.in_bitwidth = 2'(bw);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready: got %b, required 1", name, bus.in_ready);
    end
    @(posedge clk); #1;               // accepted at this edge
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL %s_early: out_valid=%b one cycle after accept, required 0", name, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_bank !== 5'(e_bank) || bus.out_entry !== 8'(e_entry) || bus.out_err !== e_err) begin
      failures++;
      $display("FAIL %s: valid=%b bank=%0d entry=%0d err=%b, required 1/%0d/%0d/%b",
               name, bus.out_valid, bus.out_bank, bus.out_entry, bus.out_err, e_bank, e_entry, e_err);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL %s_drain: out_valid=%b after handshake, required 0", name, bus.out_valid);
    end
  endtask

  task automatic test_mapping();
    send_one("bw0_r5_c7",    5,   7, 0, 22,   5, 1'b0);
    send_one("bw2_r13_c6",  13,   6, 2, 23,   3, 1'b0);
    send_one("bw1_skewwrap", 255, 15, 1, 28, 127, 1'b0);
  endtask

  task automatic test_errors();
    send_one("err_bw2_c8",   13,   8, 2, 0, 0, 1'b1);
    send_one("err_bw3",      77,   3, 3, 0, 0, 1'b1);
    send_one("err_bw0_c32",   1,  32, 0, 0, 0, 1'b1);
    send_one("after_err",     5,   7, 0, 22, 5, 1'b0);
  endtask

  // Streams req_q; checks order, result, hold-while-stalled and full rate.
  task automatic stream(input string name, input bit rnd, input bit sweep);
    int   cyc = 0;
    int   n_total;
    bit   stall = 0;
    logic [4:0] hb;
    logic [7:0] he;
    logic       herr;
    req_t e;
    int   r, c;
    bit   legal;
    n_total = req_q.size();
    while ((req_q.size() != 0 || exp_q.size() != 0) && cyc < 40000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (req_q.size() != 0) begin
        bus.in_valid = 1;
        bus.in_row = 8'(req_q[0].row); bus.in_column = 8'(req_q[0].col); bus.in_bitwidth = 2'(req_q[0].bw);
      end else bus.in_valid = 0;
      #1;
      if (stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_bank !== hb || bus.out_entry !== he || bus.out_err !== herr) begin
          failures++;
          $display("FAIL %s_hold: valid=%b bank=%0d entry=%0d err=%b, required 1/%0d/%0d/%b",
                   name, bus.out_valid, bus.out_bank, bus.out_entry, bus.out_err, hb, he, herr);
        end
      end
      if (!rnd && bus.in_valid && !bus.in_ready) begin
        checks++; failures++;
        $display("FAIL %s_full_rate: in_ready=0 with out_ready=1, required 1", name);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL %s_spurious: result bank=%0d with nothing outstanding", name, bus.out_bank);
        end else begin
          e = exp_q.pop_front();
          legal = (e.bw != 3) && (e.col < (32 >> e.bw));
          if (legal) begin
            fwd(int'(bus.out_bank), int'(bus.out_entry), e.bw, r, c);
            if (bus.out_err !== 1'b0 || r != e.row || c != e.col) begin
              failures++;
              $display("FAIL %s_roundtrip: bw=%0d got row=%0d col=%0d err=%b, required row=%0d col=%0d err=0",
                       name, e.bw, r, c, bus.out_err, e.row, e.col);
            end else if (sweep) cnt[e.bw][bus.out_entry][bus.out_bank]++;
          end else if (bus.out_err !== 1'b1 || bus.out_bank !== 5'd0 || bus.out_entry !== 8'd0) begin
            failures++;
            $display("FAIL %s_err: bw=%0d col=%0d got err=%b bank=%0d entry=%0d, required 1/0/0",
                     name, e.bw, e.col, bus.out_err, bus.out_bank, bus.out_entry);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(req_q.pop_front());
      stall = bus.out_valid && !bus.out_ready;
      hb = bus.out_bank; he = bus.out_entry; herr = bus.out_err;
      @(posedge clk); #1;
      bus.in_valid = 0;
      cyc++;
    end
    #1;
    bus.in_valid = 0;
    bus.out_ready = 1;
    if (cyc >= 40000) begin
      checks++; failures++;
      $display("FAIL %s_timeout: %0d requests / %0d results outstanding", name, req_q.size(), exp_q.size());
      req_q.delete(); exp_q.delete();
    end else if (!rnd) begin
      checks++;
      if (cyc != n_total + 2) begin
        failures++; $display("FAIL %s_throughput: %0d cycles for %0d requests, required %0d", name, cyc, n_total, n_total + 2);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    req_t q;
    for (int i = 0; i < 150; i++) begin
      q.bw  = int'($urandom_range(0, 3));
      q.row = int'($urandom_range(0, 255));
      q.col = int'($urandom_range(0, (q.bw == 3) ? 7 : (32 >> q.bw) + 3));
      req_q.push_back(q);
    end
    stream("b2b_stall", 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      q.bw = i % 3; q.row = (i * 37) % 256; q.col = (i * 5) % (32 >> q.bw);
      req_q.push_back(q);
    end
    stream("b2b_full", 1'b0, 1'b0);
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_row = 8'd5; bus.in_column = 8'd7; bus.in_bitwidth = 2'd0;
    tick();
    bus.in_row = 8'd13; bus.in_column = 8'd6; bus.in_bitwidth = 2'd2;
    tick();
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL midreset_setup: out_valid=%b, required 1", bus.out_valid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_bank !== 5'd0 || bus.out_entry !== 8'd0) begin
      failures++;
      $display("FAIL midreset_async: valid=%b bank=%0d entry=%0d, required 0/0/0",
               bus.out_valid, bus.out_bank, bus.out_entry);
    end
    tick();
    rst_n = 1;
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL midreset_stale: cycle %0d valid=%b in_ready=%b, required 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_sweep();
    req_t q;
    int   bad;
    foreach (cnt[b, e, k]) cnt[b][e][k] = 0;
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 256; r++)
        for (int c = 0; c < (32 >> b); c++) begin
          q.bw = b; q.row = r; q.col = c;
          req_q.push_back(q);
        end
    stream("sweep", 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      bad = 0;
      for (int e = 0; e < (256 >> b); e++)
        for (int k = 0; k < 32; k++)
          if (cnt[b][e][k] != 1) bad++;
      checks++;
      if (bad != 0) begin
        failures++; $display("FAIL sweep_cover_bw%0d: %0d (bank,entry) pairs not hit exactly once, required 0", b, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mapping();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
